// File: rtl/div_pkg.sv
// Shared types and constants for the addsub-based divider controller.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned NIBBLE_W = 4;
  localparam logic [NIBBLE_W-1:0] DBZ_QUOT_DEFAULT = 4'hF;

endpackage

// File: rtl/addsub.sv
// Existing 4-bit add/subtract unit.
//   A, B : operands
//   M    : 0 = add (A+B), 1 = subtract (A-B, two's complement)
//   S    : result
//   Cout : carry out; in subtract mode 1 means no borrow (A >= B)
module addsub
  import div_pkg::*;
(
  input  logic [NIBBLE_W-1:0] A,
  input  logic [NIBBLE_W-1:0] B,
  input  logic                M,
  output logic [NIBBLE_W-1:0] S,
  output logic                Cout
);

  logic [NIBBLE_W:0] sum;

  // Subtraction is A + ~B + 1.
  assign sum  = {1'b0, A} + {1'b0, B ^ {NIBBLE_W{M}}} + (NIBBLE_W+1)'(M);
  assign S    = sum[NIBBLE_W-1:0];
  assign Cout = sum[NIBBLE_W];

endmodule

// File: rtl/addsub_div_ctrl.sv
// Unsigned 4-bit restoring divider that sequences the shared addsub unit,
// one trial subtraction per clock over four iterations.
//   clk, reset          : rising-edge clock, async active-high reset
//   start               : request; accepted only while ready
//   dividend, divisor   : operands, latched on accepted start
//   ready / busy / done : IDLE / CALC / one-cycle DONE state decodes
//   quotient, remainder : result, held until the next result
//   dbz                 : divide-by-zero flag for the last operation
module addsub_div_ctrl
  import div_pkg::*;
#(
  parameter logic [NIBBLE_W-1:0] DBZ_QUOT = DBZ_QUOT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NIBBLE_W-1:0] dividend,
  input  logic [NIBBLE_W-1:0] divisor,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [NIBBLE_W-1:0] quotient,
  output logic [NIBBLE_W-1:0] remainder,
  output logic                dbz
);

  // Iteration count equals the addsub width.
  localparam int unsigned CALC_STEPS = NIBBLE_W;
  localparam int unsigned CNT_W      = $clog2(CALC_STEPS);

  state_t              state, state_next;
  logic [NIBBLE_W-1:0] r, r_next, q, q_next, d, d_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [NIBBLE_W-1:0] quot_next, rem_next;
  logic                dbz_next;

  logic [NIBBLE_W-1:0] rs, r_step, q_step, s;
  logic                cout;
  logic                m;

  // The controller only ever compares, so the unit stays in subtract mode.
  assign m  = 1'b1;
  assign rs = {r[NIBBLE_W-2:0], q[NIBBLE_W-1]};

  addsub u_addsub (
    .A    (rs),
    .B    (d),
    .M    (m),
    .S    (s),
    .Cout (cout)
  );

  assign ready = (state == IDLE);
  assign busy  = (state == CALC);
  assign done  = (state == DONE);

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      r         <= '0;
      q         <= '0;
      d         <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      state     <= state_next;
      r         <= r_next;
      q         <= q_next;
      d         <= d_next;
      cnt       <= cnt_next;
      quotient  <= quot_next;
      remainder <= rem_next;
      dbz       <= dbz_next;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_next = state;
    r_next     = r;
    q_next     = q;
    d_next     = d;
    cnt_next   = cnt;
    quot_next  = quotient;
    rem_next   = remainder;
    dbz_next   = dbz;

    // R never exceeds 7 before the shift, so Cout alone decides the bit.
    r_step = cout ? s : rs;
    q_step = {q[NIBBLE_W-2:0], cout};

    case (state)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            r_next     = '0;
            q_next     = dividend;
            d_next     = divisor;
            cnt_next   = CNT_W'(CALC_STEPS - 1);
            state_next = CALC;
          end else begin
            quot_next  = DBZ_QUOT;
            rem_next   = dividend;
            dbz_next   = 1'b1;
            state_next = DONE;
          end
        end
      end
      CALC: begin
        r_next   = r_step;
        q_next   = q_step;
        cnt_next = cnt - CNT_W'(1);
        if (cnt == '0) begin
          quot_next  = q_step;
          rem_next   = r_step;
          dbz_next   = 1'b0;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_addsub_div_ctrl.sv
// Self-checking bench for addsub_div_ctrl: directed table, exhaustive and
// random operands against a plain-arithmetic reference, plus corner sequences.
module tb_addsub_div_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] dividend, divisor;
  logic       ready, busy, done, dbz;
  logic [3:0] quotient, remainder;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  addsub_div_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  typedef struct {
    logic [3:0] dd;
    logic [3:0] dv;
    logic [3:0] eq;
    logic [3:0] er;
    logic       edbz;
    int         elat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: unsigned division; divide-by-zero reports F / dividend / 1.
  task automatic ref_div(input logic [3:0] dd, dv, output logic [3:0] eq, er,
                         output logic edbz, output int elat);
    if (dv == 0) begin
      eq = 4'hF; er = dd; edbz = 1'b1; elat = 1;
    end else begin
      eq = 4'(int'(dd) / int'(dv));
      er = 4'(int'(dd) % int'(dv));
      edbz = 1'b0; elat = 5;
    end
  endtask

  // Wait for ready (bounded), present a start for one cycle; returns at the
  // negedge right after the accepting edge.
  task automatic start_op(input string tag, input logic [3:0] dd, dv);
    int t = 0;
    while (!ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!ready) check({tag, " ready_timeout"}, 0, 1);
    start = 1'b1; dividend = dd; divisor = dv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full operation with latency, handshake and result checks.
  task automatic check_op(input string tag, input logic [3:0] dd, dv,
                          input logic [3:0] eq, er, input logic edbz,
                          input int elat);
    int lat = 1, busy_n = 0, bad_ready = 0, bad_m = 0;
    start_op(tag, dd, dv);
    dividend = ~dd; divisor = ~dv;  // later input changes must not matter
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      if (ready) bad_ready++;
      if (dut.m !== 1'b1) bad_m++;
      @(negedge clk);
      lat++;
    end
    if (ready) bad_ready++;
    check({tag, " latency"}, lat, elat);
    check({tag, " quotient"}, int'(quotient), int'(eq));
    check({tag, " remainder"}, int'(remainder), int'(er));
    check({tag, " dbz"}, int'(dbz), int'(edbz));
    check({tag, " busy_cycles"}, busy_n, elat - 1);
    check({tag, " ready_low"}, bad_ready, 0);
    check({tag, " m_is_1"}, bad_m, 0);
    @(negedge clk);
    check({tag, " done_single"}, int'(done), 0);
    check({tag, " ready_after"}, int'(ready), 1);
  endtask

  vec_t tbl[$];

  initial begin
    logic [3:0] eq, er, rd, rv;
    logic       edbz;
    int         elat, n_done;

    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("rst ready", int'(ready), 1);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst dbz", int'(dbz), 0);
    check("rst quotient", int'(quotient), 0);
    check("rst remainder", int'(remainder), 0);
    reset = 1'b0;
    @(negedge clk);

    tbl.push_back('{4'd13, 4'd4,  4'd3,  4'd1,  1'b0, 5});
    tbl.push_back('{4'd7,  4'd9,  4'd0,  4'd7,  1'b0, 5});
    tbl.push_back('{4'd15, 4'd15, 4'd1,  4'd0,  1'b0, 5});
    tbl.push_back('{4'd15, 4'd1,  4'd15, 4'd0,  1'b0, 5});
    tbl.push_back('{4'd6,  4'd0,  4'hF,  4'd6,  1'b1, 1});
    tbl.push_back('{4'd9,  4'd2,  4'd4,  4'd1,  1'b0, 5});
    tbl.push_back('{4'd0,  4'd5,  4'd0,  4'd0,  1'b0, 5});
    tbl.push_back('{4'd15, 4'd0,  4'hF,  4'd15, 1'b1, 1});
    tbl.push_back('{4'd14, 4'd3,  4'd4,  4'd2,  1'b0, 5});
    foreach (tbl[i])
      check_op($sformatf("tbl%0d", i), tbl[i].dd, tbl[i].dv, tbl[i].eq,
               tbl[i].er, tbl[i].edbz, tbl[i].elat);

    // start during CALC is ignored; exactly one done pulse.
    start_op("ign", 4'd13, 4'd4);
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      start = busy; dividend = 4'd2; divisor = 4'd1;
      if (done) begin
        n_done++;
        check("ign quotient", int'(quotient), 3);
        check("ign remainder", int'(remainder), 1);
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("ign done_count", n_done, 1);

    // Async reset in the 2nd CALC cycle aborts with no done pulse.
    start_op("rst", 4'd14, 4'd3);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort ready", int'(ready), 1);
    check("abort busy", int'(busy), 0);
    check("abort quotient", int'(quotient), 0);
    check("abort remainder", int'(remainder), 0);
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort no_done", n_done, 0);
    check_op("fresh", 4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 5);

    // Exhaustive operand sweep.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        ref_div(4'(a), 4'(b), eq, er, edbz, elat);
        check_op($sformatf("ex%0d_%0d", a, b), 4'(a), 4'(b), eq, er, edbz, elat);
      end

    // Random operands.
    for (int i = 0; i < 40; i++) begin
      rd = 4'($urandom_range(15));
      rv = 4'($urandom_range(15));
      ref_div(rd, rv, eq, er, edbz, elat);
      check_op($sformatf("rnd%0d", i), rd, rv, eq, er, edbz, elat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/addsub_div_ctrl.md
Name: addsub_div_ctrl

Overview:
- Sequential controller that reuses the existing 4-bit add/subtract unit (addsub; ports A, B, M, S, Cout) to perform unsigned 4-bit restoring division.
- One subtraction per clock, four iterations, with a start/ready/done handshake.
- Sits between the switch/LED board wrapper and the shared addsub datapath. It is the first block that sequences that datapath instead of driving it combinationally.

Parameters:
- DBZ_QUOT, 4'hF, quotient value reported on divide-by-zero.
- CALC_STEPS, 4, number of iterations; fixed by the 4-bit addsub width and must not be overridden.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a division; sampled only when ready=1
- dividend  input  4  unsigned dividend, latched on accepted start
- divisor  input  4  unsigned divisor, latched on accepted start
- ready  output  1  high in IDLE only; combinational from state
- busy  output  1  high in CALC only
- done  output  1  one-cycle pulse in DONE; quotient/remainder/dbz valid from this cycle
- quotient  output  4  result quotient, held until the next accepted start
- remainder  output  4  result remainder, held until the next accepted start
- dbz  output  1  divide-by-zero flag for the last operation, held like quotient

Behaviour:
- Reset: one clock and one reset only. Reset is asynchronous and active-high. On reset:
  - state=IDLE, so ready=1.
  - busy=0, done=0, dbz=0.
  - quotient=0, remainder=0, step counter=0, internal R/Q registers=0.
- Reset asserted mid-CALC aborts the operation immediately. No done pulse follows.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and divisor!=0: latch R=0, Q=dividend, D=divisor, cnt=3; go to CALC.
  - start=1 and divisor==0: go to DONE with quotient=DBZ_QUOT, remainder=dividend, dbz=1. Latency is 1 clock.
- CALC, one iteration per cycle:
  - Form Rs={R[2:0],Q[3]}.
  - Drive addsub with A=Rs, B=D, M=1.
  - Cout=1 (no borrow, Rs>=D): R<=S, Q<={Q[2:0],1}.
  - Cout=0: R<=Rs, Q<={Q[2:0],0}.
  - cnt decrements each cycle. When the iteration with cnt==0 completes, go to DONE and copy Q→quotient, R→remainder, dbz=0.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. start is ignored in DONE.
- Arithmetic rules:
  - R<=7 before every shift, so Rs always fits in 4 bits and Cout alone decides the quotient bit.
  - In subtract mode Cout=1 means no borrow. It is the compare result and is not a sign or overflow indication.
  - addsub is driven with M=1 at all times the controller uses it.
- Latency: start accepted at edge k, CALC at edges k+1..k+4, done high in the cycle after edge k+4. That is 5 clocks from acceptance to done.
- Throughput: one division per 6 clocks with start held high. The next acceptance is at the first IDLE cycle after DONE.
- start while busy or in DONE is ignored. Operands are not re-latched and outputs are undisturbed.
- Input changes after acceptance have no effect.
- quotient, remainder and dbz change only on entering DONE or on reset.

Decomposition:
- Shared package div_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, CALC, DONE}.
  - localparam NIBBLE_W=4.
  - localparam DBZ_QUOT_DEFAULT=4'hF.
- Sub-modules: instantiate the existing addsub unchanged. No new sub-module; controller and shift registers live in this module.

Test Plan:
- Dividend 13, divisor 4, start one cycle -> busy for 4 cycles, done pulse 5 clocks after acceptance; quotient=3, remainder=1, dbz=0.
- Dividend 7 / 9, then 15 / 15, then 15 / 1, back-to-back -> (0,7), (1,0), (15,0) respectively. ready=0 from acceptance through DONE.
- Dividend 6, divisor 0 -> done the clock after acceptance; quotient=4'hF, remainder=6, dbz=1. The next valid op (9/2 -> 4,1) clears dbz.
- Start 13/4, then during CALC drive start=1 with 2/1 -> ignored; result 3,1. Exactly one done pulse.
- Start 14/3, assert reset asynchronously at the 2nd CALC cycle (mid-period) -> ready=1, busy=0, quotient=remainder=0 immediately; no done pulse; a fresh 14/3 gives 4,2.
- Exhaustive: all 256 dividend/divisor pairs vs reference model; divisor 0 -> dbz=1 / 4'hF / dividend; also check the addsub M input is 1 throughout.
